// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared definitions for the LED display controller
//   mode_e    : display mode encoding carried on the 2-bit mode port
//   sat_shift : right shift followed by saturation to out_w bits
//   thermo    : thermometer code with min(value, width) low bits set
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BIN   = 2'd0,
    MODE_BAR   = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PEAK  = 2'd3
  } mode_e;

  // Callers keep out_w <= 32; out_w == 32 wraps max_val to all ones.
  function automatic logic [31:0] sat_shift(input logic [31:0] value, input int shift,
                                            input int out_w);
    logic [31:0] shifted;
    logic [31:0] max_val;
    shifted = value >> shift;
    max_val = (32'd1 << out_w) - 32'd1;
    return (shifted > max_val) ? max_val : shifted;
  endfunction

  function automatic logic [31:0] thermo(input logic [31:0] value, input int width);
    logic [31:0] result;
    result = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width && 32'(i) < value) result[i] = 1'b1;
    end
    return result;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - free-running 0..DIV-1 counter for the blink phase
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   clr     : synchronous clear to 0 (suppresses tick on that edge)
//   tick    : high during the cycle the counter holds DIV-1 (wraps on next edge)
module led_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick = (cnt_q == LAST) && !clr;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/led_display_ctrl.sv
// rtl/led_display_ctrl.sv - registered, mode-selectable LED display stage
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   we      : write strobe, captures wdata
//   wdata   : value to display (IN_W bits)
//   mode    : 0 BIN, 1 BAR, 2 BLINK, 3 PEAK
//   led     : registered active-high LED drive (LED_W bits)
module led_display_ctrl
  import led_pkg::*;
#(
  parameter int IN_W        = 6,
  parameter int LED_W       = 4,
  parameter int SHIFT       = 2,
  parameter int BLINK_DIV   = 25_000_000,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [IN_W-1:0]  wdata,
  input  logic [1:0]       mode,
  output logic [LED_W-1:0] led
);

  if (SHIFT < 0 || SHIFT >= IN_W || LED_W < 1 || LED_W > 32 || IN_W > 32 ||
      BLINK_DIV < 2 || HOLD_CYCLES < 1) begin : g_bad_params
    $error("led_display_ctrl: illegal parameter combination");
  end

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_CYCLES - 1);

  logic [LED_W-1:0] scaled;
  logic [LED_W-1:0] val_q, val_d;
  logic [LED_W-1:0] peak_q, peak_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [HW-1:0]    hold_q, hold_d;
  mode_e            mode_q;
  logic             phase_q, phase_d;
  logic             mode_chg;
  logic             blink_tick;

  assign scaled   = LED_W'(sat_shift(32'(wdata), SHIFT, LED_W));
  assign mode_chg = (mode != mode_q);
  assign led      = led_q;

  led_prescaler #(.DIV(BLINK_DIV)) u_blink_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (mode_chg),
    .tick    (blink_tick)
  );

  always_comb begin
    val_d   = we ? scaled : val_q;
    phase_d = phase_q;
    peak_d  = peak_q;
    hold_d  = hold_q;

    if (mode_chg)        phase_d = 1'b1;
    else if (blink_tick) phase_d = ~phase_q;

    // Decay is judged against the value being written this edge, so the
    // hold countdown starts right after the capturing write and the first
    // decrement lands HOLD_CYCLES edges later.
    if (mode_chg) begin
      peak_d = val_d;
      hold_d = HOLD_RELOAD;
    end else if (we && scaled > peak_q) begin
      peak_d = scaled;
      hold_d = HOLD_RELOAD;
    end else if (peak_q > val_d) begin
      if (hold_q == '0) begin
        peak_d = peak_q - LED_W'(1);
        hold_d = HOLD_RELOAD;
      end else begin
        hold_d = hold_q - HW'(1);
      end
    end

    // Output is built from registered state, giving one edge of latency.
    led_d = val_q;
    case (mode_q)
      MODE_BIN:   led_d = val_q;
      MODE_BAR:   led_d = LED_W'(thermo(32'(val_q), LED_W));
      MODE_BLINK: led_d = phase_q ? val_q : '0;
      MODE_PEAK:  led_d = peak_q;
      default:    led_d = val_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      val_q   <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      led_q   <= '0;
      phase_q <= 1'b1;
      mode_q  <= MODE_BIN;
    end else begin
      val_q   <= val_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
      phase_q <= phase_d;
      mode_q  <= mode_e'(mode);
    end
  end

endmodule

// File: tb/tb_led_display_ctrl.sv
// tb/tb_led_display_ctrl.sv - self-checking bench for led_display_ctrl
module tb_led_display_ctrl;

  localparam int IN_W        = 6;
  localparam int LED_W       = 4;
  localparam int SHIFT       = 2;
  localparam int BLINK_DIV   = 4;
  localparam int HOLD_CYCLES = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       we, we2;
  logic [5:0] wdata, wdata2;
  logic [1:0] mode, mode2;
  logic [3:0] led, led2;
  logic       cmp_en;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  led_display_ctrl #(
    .IN_W(IN_W), .LED_W(LED_W), .SHIFT(SHIFT),
    .BLINK_DIV(BLINK_DIV), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut (
    .clk(clk), .reset_n(reset_n), .we(we), .wdata(wdata), .mode(mode), .led(led)
  );

  led_display_ctrl #(
    .IN_W(IN_W), .LED_W(LED_W), .SHIFT(1),
    .BLINK_DIV(BLINK_DIV), .HOLD_CYCLES(HOLD_CYCLES)
  ) dut_s1 (
    .clk(clk), .reset_n(reset_n), .we(we2), .wdata(wdata2), .mode(mode2), .led(led2)
  );

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: led=%b expected %b at %0t", name, got, want, $time);
    end
  endtask

  // Model: time-based view of the display. Edge k is the k-th active edge;
  // state "at k" is what holds right after that edge.
  int m_edge = 0, m_anchor = 0, m_pbase = 0, m_pedge = 0, m_val = 0, m_mode = 0, m_prev = 0;
  logic [3:0] exp_led = 4'd0;

  function automatic int mscale(input int w);
    int s;
    s = w >> SHIFT;
    return (s > 15) ? 15 : s;
  endfunction

  function automatic int peak_at(input int k);
    int p;
    p = m_pbase - (k - m_pedge) / HOLD_CYCLES;
    return (p < m_val) ? m_val : p;
  endfunction

  function automatic bit phase_at(input int k);
    return (((k - m_anchor) / BLINK_DIV) % 2) == 0;
  endfunction

  function automatic logic [3:0] show(input int k);
    int n;
    n = (m_val < 4) ? m_val : 4;
    case (m_mode)
      0:       return 4'(m_val);
      1:       return 4'((1 << n) - 1);
      2:       return phase_at(k) ? 4'(m_val) : 4'd0;
      default: return 4'(peak_at(k));
    endcase
  endfunction

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_val = 0; m_mode = 0; m_anchor = m_edge;
      m_pbase = 0; m_pedge = m_edge; exp_led = 4'd0;
    end else begin
      m_prev  = peak_at(m_edge);
      exp_led = show(m_edge);
      m_edge++;
      if (we) m_val = mscale(int'(wdata));
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode); m_anchor = m_edge; m_pbase = m_val; m_pedge = m_edge;
      end else if (we && mscale(int'(wdata)) > m_prev) begin
        m_pbase = m_val; m_pedge = m_edge;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en && reset_n) check("model", led, exp_led);
  end

  task automatic wr(input logic [5:0] d, input logic [1:0] m);
    we = 1'b1; wdata = d; mode = m;
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; we = 1'b0; wdata = '0; mode = 2'd0;
    we2 = 1'b0; wdata2 = '0; mode2 = 2'd0; cmp_en = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_led", led, 4'b0000);
    check("reset_led_s1", led2, 4'b0000);
    reset_n = 1'b1; cmp_en = 1'b1;

    // BIN, plus saturation on the SHIFT=1 instance
    we2 = 1'b1; wdata2 = 6'd40;
    wr(6'd63, 2'd0);
    we2 = 1'b0;
    check("bin_before_latency", led, 4'b0000);
    @(negedge clk);
    check("bin_63", led, 4'b1111);
    check("bin_sat_shift1", led2, 4'b1111);

    // BAR (first write coincides with the mode change)
    wr(6'd12, 2'd1); @(negedge clk); check("bar_12", led, 4'b0111);
    wr(6'd40, 2'd1); @(negedge clk); check("bar_40", led, 4'b1111);
    wr(6'd3,  2'd1); @(negedge clk); check("bar_3", led, 4'b0000);

    // BLINK: 4 on, 4 off, repeating
    wr(6'd20, 2'd2);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("blink", led, ((i / 4) % 2 == 0) ? 4'b0101 : 4'b0000);
    end
    repeat (2) @(negedge clk);
    check("blink_off", led, 4'b0000);

    // Switch to PEAK during the off-phase
    mode = 2'd3;
    @(negedge clk);
    @(negedge clk);
    check("switch_peak", led, 4'b0101);

    // PEAK: 40 then 8, hold 3 cycles, decay one step per 3 cycles
    wr(6'd40, 2'd3);
    wr(6'd8, 2'd3);
    check("peak_hold1", led, 4'b1010);
    @(negedge clk); check("peak_hold2", led, 4'b1010);
    @(negedge clk); check("peak_hold3", led, 4'b1010);
    @(negedge clk); check("peak_dec9", led, 4'b1001);
    repeat (3) @(negedge clk); check("peak_dec8", led, 4'b1000);
    @(negedge clk);
    wr(6'd48, 2'd3);
    wr(6'd8, 2'd3);
    check("peak_rewrite", led, 4'b1100);
    @(negedge clk); check("peak_rehold2", led, 4'b1100);
    @(negedge clk); check("peak_rehold3", led, 4'b1100);
    @(negedge clk); check("peak_redec11", led, 4'b1011);
    repeat (40) @(negedge clk);
    check("peak_floor", led, 4'b0010);

    // Asynchronous reset mid-blink
    wr(6'd20, 2'd2);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check("reset_async", led, 4'b0000);
    @(negedge clk);
    mode = 2'd0; reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_reset_idle", led, 4'b0000);
    end
    wr(6'd63, 2'd0);
    @(negedge clk);
    check("post_reset_bin", led, 4'b1111);
    repeat (3) @(negedge clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
